// File: rtl/senha_pkg.sv
// Shared types and constants for the lock PIN verifier.
// pin_from_pac flattens a legacy 4-digit packet into the pin_in packing.
package senha_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    LIVRE,
    BLOQUEIO
  } estado_bloq_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] d4;
    logic [DIGIT_W-1:0] d3;
    logic [DIGIT_W-1:0] d2;
    logic [DIGIT_W-1:0] d1;
  } pinPac_t;

  function automatic logic [4*DIGIT_W-1:0] pin_from_pac(input pinPac_t pac);
    return {pac.d4, pac.d3, pac.d2, pac.d1};
  endfunction

endpackage

// File: rtl/verificador_senha_bloqueio_comparador_pin.sv
// Combinational PIN comparator: master hit, any-user hit, and the
// lowest-index matching enabled slot.
module comparador_pin
  import senha_pkg::*;
#(
  parameter  int N_DIGITS = 4,
  parameter  int N_PINS   = 4,
  localparam int PIN_W    = DIGIT_W * N_DIGITS,
  localparam int IDX_W    = (N_PINS > 1) ? $clog2(N_PINS) : 1
) (
  input  logic [PIN_W-1:0]        pin_in,
  input  logic [PIN_W-1:0]        master_pin,
  input  logic [PIN_W*N_PINS-1:0] user_pins,
  input  logic [N_PINS-1:0]       user_en,
  output logic                    hit_master,
  output logic                    hit_user,
  output logic [IDX_W-1:0]        idx
);

  assign hit_master = (pin_in == master_pin);

  // Scan from the top slot down so the lowest matching index is the last write.
  always_comb begin
    hit_user = 1'b0;
    idx      = '0;
    for (int k = N_PINS - 1; k >= 0; k--) begin
      if (user_en[k] && (user_pins[k*PIN_W +: PIN_W] == pin_in)) begin
        hit_user = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/verificador_senha_bloqueio.sv
// PIN verifier with consecutive-failure counting and timed lockout.
// Each submission yields exactly one registered result pulse one cycle later.
module verificador_senha_bloqueio
  import senha_pkg::*;
#(
  parameter  int N_DIGITS        = 4,
  parameter  int N_PINS          = 4,
  parameter  int MAX_TENTATIVAS  = 3,
  parameter  int T_BLOQUEIO      = 1000,
  parameter  int MASTER_OVERRIDE = 1,
  localparam int PIN_W           = DIGIT_W * N_DIGITS,
  localparam int IDX_W           = (N_PINS > 1) ? $clog2(N_PINS) : 1,
  localparam int TENT_W          = $clog2(MAX_TENTATIVAS + 1),
  localparam int TIMER_W         = $clog2(T_BLOQUEIO) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIN_W-1:0]        pin_in,
  input  logic                    pin_valid,
  input  logic [PIN_W-1:0]        master_pin,
  input  logic [PIN_W*N_PINS-1:0] user_pins,
  input  logic [N_PINS-1:0]       user_en,
  output logic                    senha_fail,
  output logic                    senha_padrao,
  output logic                    senha_master,
  output logic                    senha_ignorada,
  output logic [IDX_W-1:0]        pin_idx,
  output logic                    bloqueado,
  output logic [TENT_W-1:0]       tentativas
);

  logic               hitMaster;
  logic               hitUser;
  logic [IDX_W-1:0]   hitIdx;
  logic               tentLast_d;
  estado_bloq_t       estado_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TENT_W-1:0]  tent_q;
  logic [IDX_W-1:0]   idx_q;
  logic               bloq_q;

  comparador_pin #(
    .N_DIGITS(N_DIGITS),
    .N_PINS  (N_PINS)
  ) u_comparador (
    .pin_in    (pin_in),
    .master_pin(master_pin),
    .user_pins (user_pins),
    .user_en   (user_en),
    .hit_master(hitMaster),
    .hit_user  (hitUser),
    .idx       (hitIdx)
  );

  assign tentLast_d = ((int'(tent_q) + 1) >= MAX_TENTATIVAS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q       <= LIVRE;
      timer_q        <= '0;
      tent_q         <= '0;
      idx_q          <= '0;
      bloq_q         <= 1'b0;
      senha_fail     <= 1'b0;
      senha_padrao   <= 1'b0;
      senha_master   <= 1'b0;
      senha_ignorada <= 1'b0;
    end else begin
      senha_fail     <= 1'b0;
      senha_padrao   <= 1'b0;
      senha_master   <= 1'b0;
      senha_ignorada <= 1'b0;
      case (estado_q)
        LIVRE: begin
          if (pin_valid) begin
            if (hitMaster) begin
              senha_master <= 1'b1;
              tent_q       <= '0;
            end else if (hitUser) begin
              senha_padrao <= 1'b1;
              idx_q        <= hitIdx;
              tent_q       <= '0;
            end else begin
              senha_fail <= 1'b1;
              if (tentLast_d) begin
                tent_q   <= TENT_W'(MAX_TENTATIVAS);
                bloq_q   <= 1'b1;
                timer_q  <= TIMER_W'(T_BLOQUEIO - 1);
                estado_q <= BLOQUEIO;
              end else begin
                tent_q <= tent_q + TENT_W'(1);
              end
            end
          end
        end
        BLOQUEIO: begin
          // Override wins over expiry; otherwise the timer runs regardless of submissions.
          if (pin_valid && (MASTER_OVERRIDE != 0) && hitMaster) begin
            senha_master <= 1'b1;
            estado_q     <= LIVRE;
            bloq_q       <= 1'b0;
            tent_q       <= '0;
            timer_q      <= '0;
          end else begin
            if (pin_valid) senha_ignorada <= 1'b1;
            if (timer_q == '0) begin
              estado_q <= LIVRE;
              bloq_q   <= 1'b0;
              tent_q   <= '0;
            end else begin
              timer_q <= timer_q - TIMER_W'(1);
            end
          end
        end
        default: estado_q <= LIVRE;
      endcase
    end
  end

  assign pin_idx    = idx_q;
  assign bloqueado  = bloq_q;
  assign tentativas = tent_q;

endmodule

// File: tb/tb_verificador_senha_bloqueio.sv
// Directed bench: two verifiers share stimulus, one with master override
// enabled (A) and one without (B), checked against hand-computed values.
module tb_verificador_senha_bloqueio;
  import senha_pkg::*;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_MAS  = 4'b1000;
  localparam logic [3:0] P_PAD  = 4'b0100;
  localparam logic [3:0] P_FAIL = 4'b0010;
  localparam logic [3:0] P_IGN  = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pinIn;
  logic        pinValid;
  logic [15:0] masterPin;
  logic [63:0] userPins;
  logic [3:0]  userEn;

  logic       failA, padraoA, masterA, ignA, bloqA;
  logic [1:0] idxA, tentA;
  logic       failB, padraoB, masterB, ignB, bloqB;
  logic [1:0] idxB, tentB;

  int checks   = 0;
  int failures = 0;

  pinPac_t pac1234;

  always #5 clk = ~clk;

  verificador_senha_bloqueio #(
    .N_DIGITS(4), .N_PINS(4), .MAX_TENTATIVAS(3), .T_BLOQUEIO(8), .MASTER_OVERRIDE(1)
  ) dutA (
    .clk(clk), .rst(rst), .pin_in(pinIn), .pin_valid(pinValid),
    .master_pin(masterPin), .user_pins(userPins), .user_en(userEn),
    .senha_fail(failA), .senha_padrao(padraoA), .senha_master(masterA),
    .senha_ignorada(ignA), .pin_idx(idxA), .bloqueado(bloqA), .tentativas(tentA)
  );

  verificador_senha_bloqueio #(
    .N_DIGITS(4), .N_PINS(4), .MAX_TENTATIVAS(3), .T_BLOQUEIO(8), .MASTER_OVERRIDE(0)
  ) dutB (
    .clk(clk), .rst(rst), .pin_in(pinIn), .pin_valid(pinValid),
    .master_pin(masterPin), .user_pins(userPins), .user_en(userEn),
    .senha_fail(failB), .senha_padrao(padraoB), .senha_master(masterB),
    .senha_ignorada(ignB), .pin_idx(idxB), .bloqueado(bloqB), .tentativas(tentB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkA(input string tag, input logic [3:0] pul, input logic bl, input logic [1:0] tn);
    checkOutput({tag, "_pulsesA"}, {28'd0, masterA, padraoA, failA, ignA}, {28'd0, pul});
    checkOutput({tag, "_bloqA"}, {31'd0, bloqA}, {31'd0, bl});
    checkOutput({tag, "_tentA"}, {30'd0, tentA}, {30'd0, tn});
  endtask

  task automatic checkB(input string tag, input logic [3:0] pul, input logic bl, input logic [1:0] tn);
    checkOutput({tag, "_pulsesB"}, {28'd0, masterB, padraoB, failB, ignB}, {28'd0, pul});
    checkOutput({tag, "_bloqB"}, {31'd0, bloqB}, {31'd0, bl});
    checkOutput({tag, "_tentB"}, {30'd0, tentB}, {30'd0, tn});
  endtask

  // Drives one submission at the current falling edge; returns at the next
  // falling edge, where the result pulse is visible.
  task automatic applyStimulus(input logic [15:0] pin);
    pinIn    = pin;
    pinValid = 1'b1;
    @(negedge clk);
    pinValid = 1'b0;
  endtask

  initial begin
    pac1234   = '{d4: 4'h1, d3: 4'h2, d2: 4'h3, d1: 4'h4};
    rst       = 1'b1;
    pinIn     = '0;
    pinValid  = 1'b0;
    masterPin = 16'h9999;
    userPins  = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
    userEn    = 4'b0100;
    repeat (2) @(negedge clk);
    checkA("reset", P_NONE, 1'b0, 2'd0);
    checkB("reset", P_NONE, 1'b0, 2'd0);
    checkOutput("reset_idx", {30'd0, idxA}, 32'd0);
    rst = 1'b0;

    applyStimulus(pin_from_pac(pac1234));
    checkA("user2", P_PAD, 1'b0, 2'd0);
    checkOutput("user2_idx", {30'd0, idxA}, 32'd2);
    @(negedge clk);
    checkA("user2_after", P_NONE, 1'b0, 2'd0);

    userEn = 4'b0000;
    applyStimulus(16'h1234);
    checkA("slotoff", P_FAIL, 1'b0, 2'd1);

    userPins = {16'h5555, 16'h1234, 16'h0000, 16'h5555};
    userEn   = 4'b1101;
    applyStimulus(16'h5555);
    checkA("lowidx", P_PAD, 1'b0, 2'd0);
    checkOutput("lowidx_idx", {30'd0, idxA}, 32'd0);

    masterPin = 16'h5555;
    applyStimulus(16'h5555);
    checkA("masterprio", P_MAS, 1'b0, 2'd0);
    checkB("masterprio", P_MAS, 1'b0, 2'd0);
    checkOutput("masterprio_idx", {30'd0, idxA}, 32'd0);
    masterPin = 16'h9999;

    applyStimulus(16'h0000);
    checkA("lock1_f1", P_FAIL, 1'b0, 2'd1);
    applyStimulus(16'h0000);
    checkA("lock1_f2", P_FAIL, 1'b0, 2'd2);
    applyStimulus(16'h0000);
    checkA("lock1_f3", P_FAIL, 1'b1, 2'd3);
    checkB("lock1_f3", P_FAIL, 1'b1, 2'd3);
    for (int i = 0; i < 8; i++) begin
      checkOutput("lock1_hold", {31'd0, bloqA}, 32'd1);
      @(negedge clk);
    end
    checkA("lock1_end", P_NONE, 1'b0, 2'd0);
    checkB("lock1_end", P_NONE, 1'b0, 2'd0);

    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    checkA("lock2_f3", P_FAIL, 1'b1, 2'd3);
    applyStimulus(16'h1234);
    checkA("lock2_ign", P_IGN, 1'b1, 2'd3);
    checkB("lock2_ign", P_IGN, 1'b1, 2'd3);
    applyStimulus(16'h9999);
    checkA("lock2_ovr", P_MAS, 1'b0, 2'd0);
    checkB("lock2_noovr", P_IGN, 1'b1, 2'd3);
    for (int i = 0; i < 6; i++) begin
      checkOutput("lock2_holdB", {31'd0, bloqB}, 32'd1);
      @(negedge clk);
    end
    checkB("lock2_endB", P_NONE, 1'b0, 2'd0);
    checkA("lock2_idleA", P_NONE, 1'b0, 2'd0);

    applyStimulus(16'h0000);
    checkA("seq1", P_FAIL, 1'b0, 2'd1);
    applyStimulus(16'h0000);
    checkA("seq2", P_FAIL, 1'b0, 2'd2);
    applyStimulus(16'h1234);
    checkA("seq3", P_PAD, 1'b0, 2'd0);
    checkOutput("seq3_idx", {30'd0, idxA}, 32'd2);
    applyStimulus(16'h0000);
    checkA("seq4", P_FAIL, 1'b0, 2'd1);
    checkB("seq4", P_FAIL, 1'b0, 2'd1);

    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    checkA("lock3_f3", P_FAIL, 1'b1, 2'd3);
    @(negedge clk);
    applyStimulus(16'h1234);
    checkA("lock3_ign", P_IGN, 1'b1, 2'd3);
    #2 rst = 1'b1;
    #1;
    checkA("asyncrst", P_NONE, 1'b0, 2'd0);
    checkB("asyncrst", P_NONE, 1'b0, 2'd0);
    checkOutput("asyncrst_idx", {30'd0, idxA}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h1234);
    checkA("postrst", P_PAD, 1'b0, 2'd0);
    checkOutput("postrst_idx", {30'd0, idxA}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
